ransac_mem_read_master: RTL

- Avalon-MM read master that streams a contiguous block of 32-bit words out of the RANSAC on-chip memory (single-port, word-addressed, fixed read latency).
- It feeds a valid/ready point stream to the RANSAC datapath, so the accelerator pulls point data without NIOS intervention.
- A start/done control interface is driven by a control register block.

---
 rtl/ransac_mem_read_master_if.sv | 25 ++
 rtl/ransac_mem_read_master.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ransac_mem_read_master_if.sv
// Avalon-MM read bus plus the outgoing point stream of ransac_mem_read_master.
// The master modport is the read-master side; the slave modport is memory/sink.
interface ransac_mem_read_master_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output avm_address, avm_read, avm_byteenable, out_valid, out_data,
    input  avm_waitrequest, avm_readdata, out_ready
  );

  modport slave (
    input  avm_address, avm_read, avm_byteenable, out_valid, out_data,
    output avm_waitrequest, avm_readdata, out_ready
  );
endinterface

// File: rtl/ransac_mem_read_master.sv
// Block read master: fetches length words starting at base_addr and streams them
// out over valid/ready, throttling reads so returning data always has a slot.

module ransac_mem_read_master_chk #(
  parameter int CNT_W      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             reset_n,
  input logic             push,
  input logic [CNT_W-1:0] mem_count
);
  // A return landing on a full buffer means the credit accounting is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && (mem_count == CNT_W'(FIFO_DEPTH))));
endmodule

module ransac_mem_read_master #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 15,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [LEN_W-1:0]         length,
  output logic                     busy,
  output logic                     done,
  ransac_mem_read_master_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d, issued_q, issued_d, delivered_q, delivered_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [CNT_W-1:0]        in_flight_q, in_flight_d, mem_count_q, mem_count_d;
  logic [CNT_W:0]          credit_used_s;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [READ_LATENCY-1:0] acc_sr_q, acc_sr_d;
  logic [DATA_W-1:0]       mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]       mem_d [FIFO_DEPTH];
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d, avm_read_q, avm_read_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    accept_s, push_s, load_s, pop_s;

  assign accept_s = avm_read_q & ~bus.avm_waitrequest;
  assign push_s   = acc_sr_q[READ_LATENCY-1];
  assign pop_s    = out_valid_q & bus.out_ready;
  assign load_s   = (mem_count_q != {CNT_W{1'b0}}) & (~out_valid_q | bus.out_ready);

  // Return path: latency tracking, buffer writes and the registered output stage.
  always_comb begin
    acc_sr_d    = acc_sr_q << 1'b1;
    acc_sr_d[0] = accept_s;
    in_flight_d = in_flight_q + CNT_W'(accept_s) - CNT_W'(push_s);
    mem_d       = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = bus.avm_readdata;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    wr_ptr_d    = wr_ptr_q + PTR_W'(push_s);
    rd_ptr_d    = rd_ptr_q + PTR_W'(load_s);
    mem_count_d = mem_count_q + CNT_W'(push_s) - CNT_W'(load_s);
    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ptr_q];
    end else if (pop_s) begin
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
    end else begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
    end
  end

  // Control FSM and read issue; the output register counts against the credit.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    delivered_d = delivered_q + LEN_W'(pop_s);
    addr_d      = addr_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (length != {LEN_W{1'b0}})) begin
          state_d     = S_RUN;
          len_d       = length;
          addr_d      = base_addr;
          issued_d    = {LEN_W{1'b0}};
          delivered_d = {LEN_W{1'b0}};
        end else if (start) begin
          done_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (accept_s) begin
          issued_d = issued_q + LEN_W'(1'b1);
          addr_d   = addr_q + ADDR_W'(1'b1);
          if (issued_d == len_q) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (pop_s && (delivered_d == len_q)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    credit_used_s = {1'b0, in_flight_d} + {1'b0, mem_count_d} + (CNT_W+1)'(out_valid_d);
    avm_read_d    = (state_d == S_RUN) && (issued_d < len_d) && (credit_used_s < DEPTH_C);
    busy_d        = (state_d != S_IDLE);
  end

  // State registers; reset also drops any read data still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      len_q       <= {LEN_W{1'b0}};
      issued_q    <= {LEN_W{1'b0}};
      delivered_q <= {LEN_W{1'b0}};
      addr_q      <= {ADDR_W{1'b0}};
      in_flight_q <= {CNT_W{1'b0}};
      mem_count_q <= {CNT_W{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      acc_sr_q    <= {READ_LATENCY{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= {DATA_W{1'b0}};
      out_data_q  <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
      avm_read_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      addr_q      <= addr_d;
      in_flight_q <= in_flight_d;
      mem_count_q <= mem_count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      acc_sr_q    <= acc_sr_d;
      mem_q       <= mem_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      avm_read_q  <= avm_read_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.avm_address    = addr_q;
  assign bus.avm_read       = avm_read_q;
  assign bus.avm_byteenable = 4'hF;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign busy               = busy_q;
  assign done               = done_q;

  ransac_mem_read_master_chk #(.CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)) u_chk (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_s),
    .mem_count (mem_count_q)
  );
endmodule
